// File: rtl/miner_pkg.sv
// Shared types and constants for the message word assembler.
// The lane helper maps a byte position inside a word to its 8-bit lane.
package miner_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // msb_first = 1 puts byte 0 in lane 3 (bits [31:24]); otherwise in lane 0.
  function automatic logic [1:0] byte_lane(input logic [1:0] pos, input bit msb_first);
    return msb_first ? ~pos : pos;
  endfunction

endpackage

// File: rtl/msg_word_assembler_if.sv
// Byte-in / word-out handshake bundle of the message word assembler.
// The upstream/downstream side uses master, the assembler uses slave.
interface msg_word_assembler_if #(
  parameter int WORDS_PER_BLOCK = 16
) ();

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic [miner_pkg::BYTE_W-1:0] byte_in;
  logic                         byte_valid;
  logic                         byte_ready;
  logic                         clear;
  logic [miner_pkg::WORD_W-1:0] word_out;
  logic                         word_valid;
  logic                         word_ready;
  logic [IDX_W-1:0]             word_index;
  logic                         block_last;
  logic                         overrun;

  modport master (
    output byte_in, byte_valid, clear, word_ready,
    input  byte_ready, word_out, word_valid, word_index, block_last, overrun
  );

  modport slave (
    input  byte_in, byte_valid, clear, word_ready,
    output byte_ready, word_out, word_valid, word_index, block_last, overrun
  );

endinterface

// File: rtl/flex_counter.sv
// Up counter that wraps to zero after ROLLOVER, with synchronous clear
// (priority over enable) and asynchronous active-high reset.
module flex_counter #(
  parameter int               WIDTH    = 2,
  parameter logic [WIDTH-1:0] ROLLOVER = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == ROLLOVER) ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/msg_word_assembler.sv
// Packs a byte stream into 32-bit words with a one-word output register,
// per-block word index, block_last marker and a sticky overrun flag.
module msg_word_assembler
  import miner_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 16,
  parameter bit FIRST_BYTE_MSB  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  msg_word_assembler_if.slave bus
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  state_t            state, state_nx;
  logic [1:0]        byte_cnt;
  logic [IDX_W-1:0]  word_cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] next_word;
  logic [1:0]        lane;
  logic              byte_full, accept, load, handshake;

  assign bus.word_valid = (state == HOLD);
  assign byte_full      = (byte_cnt == 2'd3);
  assign handshake      = bus.word_valid && bus.word_ready;
  // Only the word-completing byte has to wait for room in the output register.
  assign bus.byte_ready = !(byte_full && bus.word_valid && !bus.word_ready);
  assign accept         = bus.byte_valid && bus.byte_ready && !bus.clear;
  assign load           = accept && byte_full;
  assign lane           = byte_lane(byte_cnt, FIRST_BYTE_MSB);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_word = acc;
    next_word[{lane, 3'b000} +: BYTE_W] = bus.byte_in;
  end

  flex_counter #(.WIDTH(2), .ROLLOVER(2'd3)) u_byte_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.clear),
    .enable (accept),
    .count  (byte_cnt)
  );

  flex_counter #(.WIDTH(IDX_W), .ROLLOVER(LAST_IDX)) u_word_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.clear),
    .enable (load),
    .count  (word_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= next_word;
    end
  end

  // Output register only moves on a load, so it holds steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.word_out   <= '0;
      bus.word_index <= '0;
      bus.block_last <= 1'b0;
    end else if (load) begin
      bus.word_out   <= next_word;
      bus.word_index <= word_cnt;
      bus.block_last <= (word_cnt == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.overrun <= 1'b0;
    end else if (bus.clear) begin
      bus.overrun <= 1'b0;
    end else if (bus.byte_valid && !bus.byte_ready) begin
      bus.overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.clear) begin
      state_nx = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (load) state_nx = HOLD;
        HOLD:    if (handshake && !load) state_nx = COLLECT;
        default: state_nx = COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_word_assembler.sv
// Directed bench for msg_word_assembler: two instances (MSB-first and
// LSB-first byte order) share stimulus; a queue scoreboard checks each word.
module tb_msg_word_assembler;

  localparam int WPB = 16;

  typedef struct {
    logic [31:0] w_msb;
    logic [31:0] w_lsb;
    int          idx;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  exp_t       exp_q[$];
  logic [7:0] model_bytes[4];
  int         model_bcnt = 0;
  int         model_wcnt = 0;

  msg_word_assembler_if #(.WORDS_PER_BLOCK(WPB)) if_m ();
  msg_word_assembler_if #(.WORDS_PER_BLOCK(WPB)) if_l ();

  assign if_l.byte_in    = if_m.byte_in;
  assign if_l.byte_valid = if_m.byte_valid;
  assign if_l.clear      = if_m.clear;
  assign if_l.word_ready = if_m.word_ready;

  msg_word_assembler #(.WORDS_PER_BLOCK(WPB), .FIRST_BYTE_MSB(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (if_m)
  );

  msg_word_assembler #(.WORDS_PER_BLOCK(WPB), .FIRST_BYTE_MSB(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_bcnt = 0;
    model_wcnt = 0;
    exp_q.delete();
  endtask

  // Offers one byte for one cycle; will_accept is the bench's expectation.
  task automatic drive_byte(input logic [7:0] b, input bit will_accept);
    exp_t e;
    if_m.byte_in    = b;
    if_m.byte_valid = 1'b1;
    #1;
    chk("byte_ready", 32'(if_m.byte_ready), 32'(will_accept));
    if (will_accept) begin
      model_bytes[model_bcnt] = b;
      model_bcnt++;
      if (model_bcnt == 4) begin
        e.w_msb = {model_bytes[0], model_bytes[1], model_bytes[2], model_bytes[3]};
        e.w_lsb = {model_bytes[3], model_bytes[2], model_bytes[1], model_bytes[0]};
        e.idx   = model_wcnt;
        e.last  = (model_wcnt == WPB - 1);
        exp_q.push_back(e);
        model_wcnt = (model_wcnt + 1) % WPB;
        model_bcnt = 0;
      end
    end
    tick();
    if_m.byte_valid = 1'b0;
  endtask

  // Scoreboard: a handshake happens on the coming edge when both are high now.
  always @(negedge clk) begin
    if (!rst && !if_m.clear && if_m.word_valid && if_m.word_ready) begin
      chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_out_msb", if_m.word_out, e.w_msb);
        chk("word_out_lsb", if_l.word_out, e.w_lsb);
        chk("word_index", 32'(if_m.word_index), 32'(e.idx));
        chk("block_last", 32'(if_m.block_last), 32'(e.last));
        chk("lsb_word_valid", 32'(if_l.word_valid), 32'd1);
      end
    end
  end

  initial begin
    if_m.byte_in    = '0;
    if_m.byte_valid = 1'b0;
    if_m.clear      = 1'b0;
    if_m.word_ready = 1'b1;

    // Reset state while rst is held
    #3;
    chk("rst_word_out", if_m.word_out, 32'h0);
    chk("rst_word_valid", 32'(if_m.word_valid), 32'd0);
    chk("rst_word_index", 32'(if_m.word_index), 32'd0);
    chk("rst_block_last", 32'(if_m.block_last), 32'd0);
    chk("rst_overrun", 32'(if_m.overrun), 32'd0);
    chk("rst_byte_ready", 32'(if_m.byte_ready), 32'd1);
    #9 rst = 1'b0;
    tick();
    chk("post_rst_byte_ready", 32'(if_m.byte_ready), 32'd1);

    // Basic word, both byte orders, one-cycle word_valid
    drive_byte(8'h11, 1'b1);
    drive_byte(8'h22, 1'b1);
    drive_byte(8'h33, 1'b1);
    drive_byte(8'h44, 1'b1);
    chk("basic_valid_hi", 32'(if_m.word_valid), 32'd1);
    chk("basic_msb_word", if_m.word_out, 32'h11223344);
    chk("basic_lsb_word", if_l.word_out, 32'h44332211);
    chk("basic_index", 32'(if_m.word_index), 32'd0);
    tick();
    chk("basic_valid_lo", 32'(if_m.word_valid), 32'd0);

    // 64-byte stream: indices 1..15 then wrap to 0
    for (int i = 0; i < 64; i++) drive_byte(8'(i * 7 + 3), 1'b1);
    chk("wrap_index", 32'(if_m.word_index), 32'd0);
    chk("wrap_last", 32'(if_m.block_last), 32'd0);
    tick();

    // Backpressure: 8 bytes with word_ready low, last one dropped
    if_m.word_ready = 1'b0;
    for (int i = 0; i < 7; i++) drive_byte(8'hA0 + 8'(i), 1'b1);
    chk("bp_ready_low", 32'(if_m.byte_ready), 32'd0);
    drive_byte(8'hA7, 1'b0);
    chk("bp_overrun", 32'(if_m.overrun), 32'd1);
    chk("bp_stable_word", if_m.word_out, exp_q[0].w_msb);
    chk("bp_stable_index", 32'(if_m.word_index), 32'(exp_q[0].idx));
    chk("bp_valid_held", 32'(if_m.word_valid), 32'd1);
    if_m.word_ready = 1'b1;
    tick();
    chk("bp_ready_back", 32'(if_m.byte_ready), 32'd1);
    if_m.clear = 1'b1;
    tick();
    if_m.clear = 1'b0;
    model_reset();
    chk("clr_overrun", 32'(if_m.overrun), 32'd0);
    chk("clr_valid", 32'(if_m.word_valid), 32'd0);

    // Clear mid-word 5 with word 4 still pending, concurrent byte ignored
    for (int i = 0; i < 16; i++) drive_byte(8'h30 + 8'(i), 1'b1);
    tick();
    if_m.word_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_byte(8'h50 + 8'(i), 1'b1);
    chk("w4_index", 32'(if_m.word_index), 32'd4);
    drive_byte(8'h60, 1'b1);
    drive_byte(8'h61, 1'b1);
    if_m.clear      = 1'b1;
    if_m.byte_in    = 8'hEE;
    if_m.byte_valid = 1'b1;
    tick();
    if_m.clear      = 1'b0;
    if_m.byte_valid = 1'b0;
    model_reset();
    chk("clr5_valid", 32'(if_m.word_valid), 32'd0);
    if_m.word_ready = 1'b1;
    drive_byte(8'hC1, 1'b1);
    drive_byte(8'hC2, 1'b1);
    drive_byte(8'hC3, 1'b1);
    drive_byte(8'hC4, 1'b1);
    chk("clr5_index", 32'(if_m.word_index), 32'd0);
    chk("clr5_word", if_m.word_out, 32'hC1C2C3C4);
    tick();

    // Asynchronous reset mid-cycle with a held word and overrun set
    if_m.word_ready = 1'b0;
    for (int i = 0; i < 7; i++) drive_byte(8'h70 + 8'(i), 1'b1);
    drive_byte(8'h77, 1'b0);
    chk("pre_rst_overrun", 32'(if_m.overrun), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_word_valid", 32'(if_m.word_valid), 32'd0);
    chk("arst_word_out", if_m.word_out, 32'h0);
    chk("arst_overrun", 32'(if_m.overrun), 32'd0);
    chk("arst_byte_ready", 32'(if_m.byte_ready), 32'd1);
    model_reset();
    #2 rst = 1'b0;
    tick();
    if_m.word_ready = 1'b1;

    // Reset mid-word discards partial bytes
    drive_byte(8'h81, 1'b1);
    drive_byte(8'h82, 1'b1);
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    tick();
    drive_byte(8'hD1, 1'b1);
    drive_byte(8'hD2, 1'b1);
    drive_byte(8'hD3, 1'b1);
    drive_byte(8'hD4, 1'b1);
    chk("fresh_word", if_m.word_out, 32'hD1D2D3D4);
    chk("fresh_index", 32'(if_m.word_index), 32'd0);
    tick();
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_word_assembler.md
MSG_WORD_ASSEMBLER -- requirements
Module: msg_word_assembler

Interface
REQ-001 Parameter WORDS_PER_BLOCK, default 16: number of 32-bit words per message block (power of two, 2..64).
REQ-002 Parameter FIRST_BYTE_MSB, default 1: 1 = first byte of a word lands in bits [31:24]; 0 = first byte lands in bits [7:0].
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 byte_in  input  8  parallel byte from the upstream serial-to-parallel stage.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  assembler can accept a byte this cycle.
REQ-008 clear  input  1  synchronous abort of the current block.
REQ-009 word_out  output  32  assembled word.
REQ-010 word_valid  output  1  word_out holds an unconsumed word.
REQ-011 word_ready  input  1  downstream accepts word_out when word_valid is high.
REQ-012 word_index  output  $clog2(WORDS_PER_BLOCK)  position of word_out within its block.
REQ-013 block_last  output  1  word_out is the final word of its block; qualified by word_valid.
REQ-014 overrun  output  1  sticky flag: a byte was offered while byte_ready was low.

Function
REQ-015 Byte accept occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-016 A 2-bit byte counter (0..3) and a 32-bit accumulator track bytes; each accept stores byte_in in the lane selected by the counter and FIRST_BYTE_MSB, then increments the counter mod 4.
REQ-017 The 4th accept transfers {accumulator, byte_in} to the output register in the same edge; word_valid rises the next cycle (latency 1 clock after the 4th byte).
REQ-018 Word handshake completes when word_valid and word_ready are both high; word_valid then drops unless a new word is loaded on that same edge.
REQ-019 Simultaneous 4th-byte accept and word handshake: the new word is loaded, word_valid stays high, and no bubble is inserted.
REQ-020 byte_ready = NOT (byte counter == 3 AND word_valid AND NOT word_ready); bytes 0..2 are always accepted.
REQ-021 byte_valid while byte_ready is low: the byte is dropped, accumulator and counter are unchanged, and overrun is set.
REQ-022 A word counter (width of word_index) increments on each word loaded into the output register and wraps from WORDS_PER_BLOCK-1 to 0; word_index and block_last are registered with word_out.
REQ-023 block_last = 1 exactly when word_index == WORDS_PER_BLOCK-1.
REQ-024 FSM states: COLLECT (output register empty), HOLD (word_valid high). COLLECT->HOLD on 4th-byte accept. HOLD->COLLECT on handshake without a new load. HOLD->HOLD otherwise.
REQ-025 clear: the next edge zeroes the byte counter, word counter, accumulator, word_valid and overrun, and enters COLLECT; a byte_valid in the same cycle is ignored; clear has priority over every other event.
REQ-026 word_out, word_index and block_last remain stable while word_valid is high and word_ready is low.

Reset
REQ-027 While rst is high: word_out = 0, word_valid = 0, word_index = 0, block_last = 0, overrun = 0, byte counter = 0, accumulator = 0, state = COLLECT.
REQ-028 byte_ready is 1 during and immediately after reset.
REQ-029 rst asserted mid-word or mid-block discards all partial data; the first accept after release is byte 0 of word 0.

Structure
REQ-030 A shared package miner_pkg holds the FSM state enum (COLLECT, HOLD), BYTE_W = 8 and WORD_W = 32.
REQ-031 One sub-module, flex_counter (parameterised width and rollover value, with clear and enable inputs), is instantiated twice: once as the byte counter and once as the word counter.

Verification
REQ-032 Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with word_ready = 1 and FIRST_BYTE_MSB = 1 -> word_out = 0x11223344, word_valid high for 1 cycle, word_index = 0.
REQ-033 Same stimulus with FIRST_BYTE_MSB = 0 -> word_out = 0x44332211.
REQ-034 Stream 64 bytes with word_ready = 1 -> 16 words; block_last high only on word_index 15; the 17th word has word_index 0.
REQ-035 word_ready held 0 while 8 bytes are offered back-to-back -> byte_ready falls after the 7th byte, the 8th byte is dropped, overrun = 1, and word 0 remains stable.
REQ-036 Assert clear after 2 bytes of word 5 -> word_valid = 0 next cycle; the following 4 bytes yield word_index 0.
REQ-037 Pulse rst asynchronously (mid-cycle) with word_valid high -> word_valid, word_out and overrun are 0 immediately, and byte_ready = 1.
